mixer_acc_dump: RTL and testbench
=================================

// Module: mixer_acc_dump
// PURPOSE
//  Accumulate-and-dump integrator on the consumer side of the DDS x ADC mixer multiplier.
//  - Takes the signed 32-bit mixer product stream.
//  - Discards the first SKIP_BEATS beats after start (mixer pipeline flush).
//  - Sums exactly n_samples beats with saturation.
//  - Presents one accumulated result under a valid/ready handshake, for the
//    magnitude/phase stage of the frequency-response detector.
// PARAMETERS
//  DIN_W       32  width of signed product input
//  CNT_W       24  width of sample counter / n_samples
//  ACC_W       64  width of signed accumulator and result (ACC_W > DIN_W)
//  SKIP_BEATS  2   valid beats discarded after start before accumulation
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  start      in   1      one-cycle pulse: begin a measurement (honoured only in IDLE)
//  n_samples  in   CNT_W  beats to accumulate, sampled on accepted start
//  din        in   DIN_W  signed mixer product
//  din_valid  in   1      din qualifier; no backpressure toward mixer
//  acc        out  ACC_W  signed accumulated result, stable while acc_valid=1
//  acc_valid  out  1      result available
//  acc_ready  in   1      consumer accepts result when acc_valid & acc_ready
//  ovf        out  1      saturation occurred during this measurement; valid with acc
//  busy       out  1      high in SKIP, ACCUM, DONE
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge):
//  - state=IDLE; acc=0, acc_valid=0, ovf=0, busy=0; counters=0.
//  - Applies from any state, including mid-measurement; the partial sum is discarded.
//  IDLE:
//  - start=1 & n_samples!=0: latch N=n_samples, clear acc, ovf and counters.
//  - Next state is SKIP, or ACCUM if SKIP_BEATS=0.
//  - start=1 & n_samples==0: ignored, remain IDLE.
//  SKIP:
//  - Each din_valid beat is discarded and counted.
//  - On the SKIP_BEATS-th beat, go to ACCUM. That beat is not summed.
//  ACCUM:
//  - Each din_valid beat: acc <= sat(acc + sign_ext(din)); sample count++.
//  - Cycles with din_valid=0 hold all state.
//  - On the beat that makes count==N, go to DONE.
//  - acc_valid=1 from the next cycle, i.e. 1-cycle latency after the last beat's edge.
//  Saturation:
//  - Signed overflow of the ACC_W add clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
//  - ovf is set sticky until the next accepted start.
//  - Further beats still count toward N and keep the clamp if still overflowing.
//  DONE:
//  - acc, ovf held; acc_valid=1.
//  - din beats ignored; start ignored.
//  - acc_valid & acc_ready: acc_valid<=0, state<=IDLE.
//  - acc and ovf keep their last values until the next accepted start.
//  - A start in the same cycle as the handshake is ignored; start is only accepted in IDLE.
//  Counter width:
//  - N up to 2^CNT_W-1 is supported.
//  - The count never wraps because it stops at N.
//  busy: combinational decode of state; 0 only in IDLE.
// TESTING
//  1. Basic sum:
//     - Stimulus: N=4, SKIP_BEATS=2. Beats 999,999 (discarded) then 100,-50,7,1,
//       with 3-cycle din_valid gaps between beats.
//     - Response: acc=58, ovf=0, acc_valid rises 1 cycle after beat 1 is clocked in.
//  2. Saturation:
//     - Stimulus: ACC_W=34, N=5, five beats of 0x7FFFFFFF after the skip beats.
//     - Response: acc=0x1_FFFF_FFFF, ovf=1.
//     - Repeat with 0x80000000: acc=-2^33, ovf=1.
//  3. Backpressure:
//     - Stimulus: hold acc_ready=0 for 10 cycles after acc_valid, pulse start,
//       and drive extra din beats.
//     - Response: acc, acc_valid and ovf unchanged; start ignored; IDLE one cycle
//       after acc_ready=1.
//  4. Zero / busy start:
//     - start with n_samples=0 -> stays IDLE, busy=0.
//     - start during ACCUM (N=8, after 3 beats) -> ignored; final acc covers only
//       the first measurement.
//  5. Reset mid-operation:
//     - Stimulus: rst_n=0 for 1 cycle after 2 of N=6 beats.
//     - Response: acc=0, acc_valid=0, busy=0 next edge.
//     - A new start with N=1, din=-5 then gives acc=-5.
//  6. Back-to-back:
//     - Stimulus: handshake, then start on the following cycle with N=1, din=3.
//     - Response: second result acc=3, ovf cleared even if the first run saturated.

Source files
------------

// File: rtl/mixer_acc_dump.sv
// Accumulate-and-dump integrator for the DDS x ADC mixer product stream.
// Skips pipeline-flush beats, sums N beats with saturation, and hands one result out under valid/ready.
module mixer_acc_dump #(
    parameter int DIN_W      = 32,
    parameter int CNT_W      = 24,
    parameter int ACC_W      = 64,
    parameter int SKIP_BEATS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam int SKIP_W = (SKIP_BEATS < 2) ? 1 : $clog2(SKIP_BEATS + 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_BEATS - 1);
    localparam logic [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   n_lat;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic               start_ok;
    logic               last_beat;
    logic               skip_done;
    logic [ACC_W:0]     sum_ext;
    logic               sum_ovf;
    logic [ACC_W-1:0]   sum_sat;

    assign start_ok  = start && (n_samples != '0);
    assign cnt_nxt   = cnt + 1'b1;
    assign last_beat = (cnt_nxt == n_lat);
    assign skip_done = (skip_cnt == SKIP_LAST);

    // One guard bit: the add overflowed exactly when the guard and sign bits disagree.
    assign sum_ext = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-DIN_W){din[DIN_W-1]}}, din};
    assign sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign sum_sat = sum_ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                             : sum_ext[ACC_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = (SKIP_BEATS == 0) ? S_ACCUM : S_SKIP;
            end
            S_SKIP: begin
                if (din_valid && skip_done) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (din_valid && last_beat) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (acc_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result and ovf persist through DONE and IDLE until the next accepted start clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lat    <= '0;
            cnt      <= '0;
            skip_cnt <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        n_lat    <= n_samples;
                        cnt      <= '0;
                        skip_cnt <= '0;
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (din_valid) skip_cnt <= skip_cnt + 1'b1;
                end
                S_ACCUM: begin
                    if (din_valid) begin
                        acc_q <= sum_sat;
                        ovf_q <= ovf_q | sum_ovf;
                        cnt   <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc       = acc_q;
    assign ovf       = ovf_q;
    assign acc_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mixer_acc_dump.sv
// Self-checking bench for mixer_acc_dump: a 64-bit and a 34-bit accumulator share one stimulus
// stream and are compared against a saturating-sum reference model.
module tb_mixer_acc_dump;

    localparam int SKIP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] n_samples = '0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        acc_ready = 1'b0;

    logic [63:0] acc64;
    logic [33:0] acc34;
    logic        valid64, valid34, ovf64, ovf34, busy64, busy34;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mixer_acc_dump dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .din(din), .din_valid(din_valid), .acc(acc64), .acc_valid(valid64),
        .acc_ready(acc_ready), .ovf(ovf64), .busy(busy64)
    );

    mixer_acc_dump #(.ACC_W(34)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .din(din), .din_valid(din_valid), .acc(acc34), .acc_valid(valid34),
        .acc_ready(acc_ready), .ovf(ovf34), .busy(busy34)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: drop the flush beats, then add N beats one by one, clamping to the w-bit range.
    function automatic void model(input int n, input logic signed [31:0] q[$], input int w,
                                  output logic signed [127:0] res, output logic o);
        logic signed [127:0] mx, mn, s, d;
        mx  = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn  = -mx - 128'sd1;
        res = '0;
        o   = 1'b0;
        for (int i = SKIP; i < SKIP + n; i++) begin
            d = q[i];
            s = res + d;
            if (s > mx) begin res = mx; o = 1'b1; end
            else if (s < mn) begin res = mn; o = 1'b1; end
            else res = s;
        end
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "/busy64"}, 128'(busy64), 128'(0));
        check({tag, "/busy34"}, 128'(busy34), 128'(0));
        check({tag, "/valid64"}, 128'(valid64), 128'(0));
        check({tag, "/valid34"}, 128'(valid34), 128'(0));
    endtask

    task automatic check_result(input string tag, input logic signed [127:0] e64, input logic o64,
                                input logic signed [127:0] e34, input logic o34);
        check({tag, "/valid64"}, 128'(valid64), 128'(1));
        check({tag, "/valid34"}, 128'(valid34), 128'(1));
        check({tag, "/acc64"}, {64'd0, acc64}, {64'd0, e64[63:0]});
        check({tag, "/acc34"}, {94'd0, acc34}, {94'd0, e34[33:0]});
        check({tag, "/ovf64"}, 128'(ovf64), 128'(o64));
        check({tag, "/ovf34"}, 128'(ovf34), 128'(o34));
    endtask

    // gap < 0 selects a random 0..3 idle gap between beats; pulse_at injects a start before that beat.
    task automatic run_meas(input string tag, input int n, input logic signed [31:0] q[$],
                            input int gap, input int pulse_at,
                            output logic signed [127:0] e64, output logic o64,
                            output logic signed [127:0] e34, output logic o34);
        int g;
        model(n, q, 64, e64, o64);
        model(n, q, 34, e34, o34);
        start = 1'b1;
        n_samples = 24'(n);
        step();
        start = 1'b0;
        check({tag, "/busy"}, 128'({busy64, busy34}), 128'(2'b11));
        for (int i = 0; i < q.size(); i++) begin
            if (i == pulse_at) begin
                start = 1'b1;
                n_samples = 24'd2;
                step();
                start = 1'b0;
            end
            if (i == q.size() - 1)
                check({tag, "/pre_valid"}, 128'({valid64, valid34}), 128'(0));
            din = q[i];
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            if (i < q.size() - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                repeat (g) step();
            end
        end
        check_result(tag, e64, o64, e34, o34);
    endtask

    task automatic handshake(input string tag);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [31:0] q[$];
        logic signed [127:0] e64, e34, h64, h34;
        logic o64, o34, ho64, ho34;
        int n;

        // Reset state
        repeat (2) step();
        check_idle("reset");
        check("reset/acc64", {64'd0, acc64}, 128'(0));
        check("reset/acc34", {94'd0, acc34}, 128'(0));
        check("reset/ovf", 128'({ovf64, ovf34}), 128'(0));
        rst_n = 1'b1;
        step();

        // Basic sum with 3-cycle gaps
        q = '{32'sd999, 32'sd999, 32'sd100, -32'sd50, 32'sd7, 32'sd1};
        run_meas("basic", 4, q, 3, -1, e64, o64, e34, o34);
        check("basic/const", {64'd0, acc64}, 128'(58));
        handshake("basic_hs");

        // Positive and negative saturation
        q = '{32'sd0, 32'sd0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        run_meas("sat_pos", 5, q, 0, -1, e64, o64, e34, o34);
        check("sat_pos/const34", {94'd0, acc34}, {94'd0, 34'h1_FFFF_FFFF});
        handshake("sat_pos_hs");
        q = '{32'sd0, 32'sd0, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
        run_meas("sat_neg", 5, q, 0, -1, e64, o64, e34, o34);
        check("sat_neg/const34", {94'd0, acc34}, {94'd0, 34'h2_0000_0000});

        // Backpressure: result frozen against start pulses and extra din beats
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            n_samples = 24'd5;
            din = $urandom;
            din_valid = 1'b1;
            step();
        end
        start = 1'b0;
        din_valid = 1'b0;
        check_result("bp_hold", e64, o64, e34, o34);
        acc_ready = 1'b1;
        start = 1'b1;
        n_samples = 24'd3;
        step();
        acc_ready = 1'b0;
        start = 1'b0;
        check_idle("bp_release");
        check("bp_release/acc34", {94'd0, acc34}, {94'd0, e34[33:0]});
        step();
        check_idle("bp_start_ignored");

        // Zero-length start is ignored
        start = 1'b1;
        n_samples = 24'd0;
        step();
        start = 1'b0;
        check_idle("zero_start");

        // Start during ACCUM is ignored
        q = '{32'sd5, 32'sd6, 32'sd10, 32'sd20, 32'sd30, 32'sd40, 32'sd50, 32'sd60, 32'sd70, 32'sd80};
        run_meas("busy_start", 8, q, 1, 5, e64, o64, e34, o34);
        check("busy_start/const", {64'd0, acc64}, 128'(360));
        handshake("busy_start_hs");

        // Reset mid-measurement after 2 of 6 beats
        start = 1'b1;
        n_samples = 24'd6;
        step();
        start = 1'b0;
        foreach (q[i]) if (i < 4) begin
            din = (i < 2) ? 32'd0 : 32'sh7FFFFFFF;
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("mid_reset");
        check("mid_reset/acc64", {64'd0, acc64}, 128'(0));
        check("mid_reset/acc34", {94'd0, acc34}, 128'(0));
        q = '{32'sd0, 32'sd0, -32'sd5};
        run_meas("post_reset", 1, q, 0, -1, e64, o64, e34, o34);
        check("post_reset/const", {64'd0, acc64}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFB});
        handshake("post_reset_hs");

        // Back-to-back: saturated run, handshake, start on the very next cycle
        q = '{32'sd0, 32'sd0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        run_meas("b2b_first", 5, q, 0, -1, e64, o64, e34, o34);
        handshake("b2b_hs");
        q = '{32'sd0, 32'sd0, 32'sd3};
        run_meas("b2b_second", 1, q, 0, -1, e64, o64, e34, o34);
        check("b2b_second/ovf34_cleared", 128'(ovf34), 128'(0));
        handshake("b2b_second_hs");

        // Randomized measurements with random gaps, values and consumer delay
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < SKIP + n; i++) begin
                case ($urandom_range(0, 2))
                    0:       q.push_back(32'sh7FFFFFFF);
                    1:       q.push_back(32'sh80000000);
                    default: q.push_back($urandom);
                endcase
            end
            run_meas($sformatf("rand%0d", r), n, q, -1, -1, h64, ho64, h34, ho34);
            repeat ($urandom_range(0, 3)) step();
            check_result($sformatf("rand%0d_wait", r), h64, ho64, h34, ho34);
            handshake($sformatf("rand%0d_hs", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
